wbu_gpr: RTL
============

Name: wbu_gpr

Overview:
Writeback unit and general-purpose register file for the NPC core. It is the write side of the path that feeds the execute stage's gpr_rdata1/gpr_rdata2 operands. It accepts EXU results over a valid/ready handshake, holds them in a one-entry writeback stage, and commits them to the GPR array. Its two combinational read ports return the operands, with bypass from the pending entry, and it counts retired instructions.

Parameters:
DATAWIDTH, 32, width of each GPR and of result data
ADDRWIDTH, 5, register index width; array holds 2**ADDRWIDTH registers

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  EXU result valid
in_ready  output  1  writeback stage can accept a result this cycle
in_rd  input  ADDRWIDTH  destination register index
in_wen  input  1  result writes a GPR (0 = retire without write)
in_data  input  DATAWIDTH  EXU_data result
wb_stall  input  1  blocks commit of the pending entry (e.g. bus busy)
rs1_addr  input  ADDRWIDTH  read port 1 index
rs2_addr  input  ADDRWIDTH  read port 2 index
gpr_rdata1  output  DATAWIDTH  read port 1 data (combinational)
gpr_rdata2  output  DATAWIDTH  read port 2 data (combinational)
retire_valid  output  1  one-cycle pulse per committed entry
retire_cnt  output  32  total committed entries

Behaviour:
- Reset (rst_n low, asynchronous): all GPRs = 0; pend_valid = 0; retire_valid = 0; retire_cnt = 0. in_ready = 1 as soon as rst_n is high.
- Pending stage: registers pend_valid, pend_rd, pend_wen and pend_data.
- Commit condition: commit = pend_valid && !wb_stall.
- in_ready = !pend_valid || !wb_stall. This is combinational from pend_valid and wb_stall; it does not depend on in_valid.
- Accept condition: accept = in_valid && in_ready. On accept, the pending stage loads in_rd, in_wen and in_data, and pend_valid becomes 1.
- Commit then accept in the same cycle: the old entry commits and the new entry replaces it. There is no bubble, so throughput is 1 result per cycle while wb_stall = 0.
- Commit without accept: pend_valid becomes 0.
- Neither commit nor accept: the pending stage holds.
- Write latency: the GPR array updates at the clock edge where commit = 1, and only when pend_wen = 1 and pend_rd != 0.
- x0: writes to index 0 are discarded, but the entry still retires. Reads of index 0 always return 0, including via bypass.
- Read ports: gpr_rdataN = 0 if rsN_addr == 0.
  - Otherwise, if pend_valid && pend_wen && pend_rd == rsN_addr, return pend_data (bypass).
  - Otherwise, return GPR[rsN_addr].
  - Both ports are independent and may use the same address.
- Retire: retire_valid is a registered pulse, high for the cycle after each commit edge. retire_cnt increments by 1 at each commit edge, wraps 0xFFFFFFFF -> 0, and is visible in the same cycle as retire_valid.
- wb_stall asserted while pend_valid = 0 has no effect; in_ready stays 1.
- Holding rules: in_data, in_rd and in_wen are sampled only on accept. The upstream source holds them stable while in_valid && !in_ready.
- Reset mid-operation: the pending entry is dropped without commit, the array clears, and the counter clears.
- Arithmetic: no sign or width conversion; data is stored bit-exact at DATAWIDTH.

Test Plan:
- Reset then read all registers: rsN_addr = 0..31 -> gpr_rdata1/2 = 0; in_ready = 1; retire_cnt = 0.
- Single write: in_valid = 1, in_rd = 5, in_wen = 1, in_data = 0xDEADBEEF.
  - Next cycle (pending): rs1_addr = 5 -> 0xDEADBEEF via bypass.
  - After commit: GPR[5] = 0xDEADBEEF, retire_valid pulses once, retire_cnt = 1.
- x0 write: in_rd = 0, in_wen = 1, in_data = 0x12345678 -> rs1_addr = 0 reads 0 while pending and after commit; retire_cnt increments.
- Back-to-back with stall:
  - Stimulus: send rd = 1/0x11, rd = 2/0x22, rd = 3/0x33 on consecutive cycles, and assert wb_stall for 3 cycles after the first accept.
  - Required: in_ready = 0 during the stall.
  - Required: no entry is lost or duplicated; final GPR[1,2,3] = 0x11, 0x22, 0x33; retire_cnt = 3.
- Same-register overwrite and wen = 0:
  - Stimulus: rd = 7/0xAAAA0000, then rd = 7/0x0000BBBB, then rd = 7 with wen = 0 and data 0xFFFFFFFF.
  - Required: GPR[7] = 0x0000BBBB; rs1_addr = rs2_addr = 7 both read 0x0000BBBB; retire_cnt = 3.
- Reset mid-operation: with a pending entry rd = 9 and wb_stall = 1, pulse rst_n low asynchronously -> pend_valid = 0 immediately, GPR[9] = 0, retire_cnt = 0, and no retire_valid pulse.

Source files
------------

// File: rtl/wbu_gpr.sv
// wbu_gpr: one-entry writeback stage feeding a GPR file with bypassed read ports and retire counting
module wbu_gpr #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDRWIDTH-1:0] in_rd,
  input  logic                 in_wen,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 wb_stall,
  input  logic [ADDRWIDTH-1:0] rs1_addr,
  input  logic [ADDRWIDTH-1:0] rs2_addr,
  output logic [DATAWIDTH-1:0] gpr_rdata1,
  output logic [DATAWIDTH-1:0] gpr_rdata2,
  output logic                 retire_valid,
  output logic [31:0]          retire_cnt
);
  localparam int NREG = 2 ** ADDRWIDTH;
  logic [DATAWIDTH-1:0] gpr_q [NREG];
  logic [DATAWIDTH-1:0] gpr_d [NREG];
  logic                 pend_valid_q, pend_valid_d;
  logic                 pend_wen_q, pend_wen_d;
  logic [ADDRWIDTH-1:0] pend_rd_q, pend_rd_d;
  logic [DATAWIDTH-1:0] pend_data_q, pend_data_d;
  logic                 retire_valid_q, retire_valid_d;
  logic [31:0]          retire_cnt_q, retire_cnt_d;
  logic                 commit, accept;

  assign in_ready = !pend_valid_q || !wb_stall;

  always_comb begin
    commit = pend_valid_q && !wb_stall;
    accept = in_valid && in_ready;
    gpr_d = gpr_q;
    if (commit && pend_wen_q && pend_rd_q != '0) gpr_d[pend_rd_q] = pend_data_q;
    pend_valid_d = accept || (pend_valid_q && !commit);
    pend_rd_d = accept ? in_rd : pend_rd_q;
    pend_wen_d = accept ? in_wen : pend_wen_q;
    pend_data_d = accept ? in_data : pend_data_q;
    retire_valid_d = commit;
    retire_cnt_d = retire_cnt_q + 32'(commit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_q <= '{default: '0};
      pend_valid_q <= 1'b0;
      pend_wen_q <= 1'b0;
      pend_rd_q <= '0;
      pend_data_q <= '0;
      retire_valid_q <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      pend_valid_q <= pend_valid_d;
      pend_wen_q <= pend_wen_d;
      pend_rd_q <= pend_rd_d;
      pend_data_q <= pend_data_d;
      retire_valid_q <= retire_valid_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // x0 reads as zero even when the pending entry targets it
  function automatic logic [DATAWIDTH-1:0] read_port(input logic [ADDRWIDTH-1:0] a);
    return (a == '0) ? '0 :
           (pend_valid_q && pend_wen_q && pend_rd_q == a) ? pend_data_q : gpr_q[a];
  endfunction

  assign gpr_rdata1 = read_port(rs1_addr);
  assign gpr_rdata2 = read_port(rs2_addr);
  assign retire_valid = retire_valid_q;
  assign retire_cnt = retire_cnt_q;
endmodule
